// File: rtl/if_id_decode_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer.
// Pre-decodes the opcode into a registered one-hot class.
module if_id_decode_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [XLEN-1:0]  In_Pc,
    input  logic [XLEN-1:0]  In_Instr,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [XLEN-1:0]  Out_Pc,
    output logic [XLEN-1:0]  Out_Instr,
    output logic [10:0]      Out_Class,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_Count
);

    localparam int C_LUI    = 0;
    localparam int C_AUIPC  = 1;
    localparam int C_JAL    = 2;
    localparam int C_JALR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_LOAD   = 5;
    localparam int C_STORE  = 6;
    localparam int C_OPIMM  = 7;
    localparam int C_OP     = 8;
    localparam int C_SYSTEM = 9;
    localparam int C_ILL    = 10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [10:0]     cls;
    } entry_t;

    function automatic logic [10:0] decode(
        input logic [6:0] op,
        input logic [2:0] f3
    );
        logic [10:0] c;
        c = '0;
        if (op[1:0] != 2'b11) begin
            c[C_ILL] = 1'b1;
        end else begin
            unique case (op)
                7'b0110111: c[C_LUI]   = 1'b1;
                7'b0010111: c[C_AUIPC] = 1'b1;
                7'b1101111: c[C_JAL]   = 1'b1;
                7'b1100111:
                    c[(f3 == 3'b000) ? C_JALR : C_ILL] = 1'b1;
                7'b1100011:
                    c[(f3 == 3'b010 || f3 == 3'b011)
                      ? C_ILL : C_BRANCH] = 1'b1;
                7'b0000011:
                    c[(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                      ? C_ILL : C_LOAD] = 1'b1;
                7'b0100011:
                    c[(f3 <= 3'b010) ? C_STORE : C_ILL] = 1'b1;
                7'b0010011: c[C_OPIMM]  = 1'b1;
                7'b0110011: c[C_OP]     = 1'b1;
                7'b1110011: c[C_SYSTEM] = 1'b1;
                default:    c[C_ILL]    = 1'b1;
            endcase
        end
        return c;
    endfunction

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_ent;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_rdy_q, in_rdy_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             consume;

    assign accept  = In_Valid & in_rdy_q;
    assign consume = main_v_q & Out_Ready;

    always_comb begin
        in_ent   = '{pc:    In_Pc,
                     instr: In_Instr,
                     cls:   decode(In_Instr[6:0], In_Instr[14:12])};
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        halted_d = halted_q |
                   (consume && main_q.instr == XLEN'(32'h0000_0073));
        cnt_d    = cnt_q + CNT_W'(consume);

        if (Flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || consume) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) skid_d = in_ent;
            end else begin
                main_v_d = accept;
                if (accept) main_d = in_ent;
            end
        end else if (accept && !skid_v_q) begin
            // main is stalled: park the new entry in skid
            skid_v_d = 1'b1;
            skid_d   = in_ent;
        end

        in_rdy_d = !skid_v_d && !halted_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            in_rdy_q <= 1'b1;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            in_rdy_q <= in_rdy_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign In_Ready    = in_rdy_q;
    assign Out_Valid   = main_v_q;
    assign Out_Pc      = main_q.pc;
    assign Out_Instr   = main_q.instr;
    assign Out_Class   = main_q.cls;
    assign Halted      = halted_q;
    assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_if_id_decode_reg.sv
// Bench for if_id_decode_reg: decode table, skid backpressure,
// flush, halt and counter wrap, checked through a scoreboard.
module tb_if_id_decode_reg;

    logic        clk;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_Pc;
    logic [31:0] In_Instr;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Pc;
    logic [31:0] Out_Instr;
    logic [10:0] Out_Class;
    logic        Halted;
    logic [31:0] Instr_Count;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_instr;
    logic [10:0] w_out_class;
    logic        w_halted;
    logic [3:0]  w_cnt;

    if_id_decode_reg #(.XLEN(32), .CNT_W(32)) dut (
        .Clock(clk), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Pc(In_Pc), .In_Instr(In_Instr), .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Pc(Out_Pc), .Out_Instr(Out_Instr),
        .Out_Class(Out_Class), .Halted(Halted),
        .Instr_Count(Instr_Count)
    );

    if_id_decode_reg #(.XLEN(32), .CNT_W(4)) dut_w (
        .Clock(clk), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(w_in_ready),
        .In_Pc(In_Pc), .In_Instr(In_Instr), .Flush(Flush),
        .Out_Valid(w_out_valid), .Out_Ready(Out_Ready),
        .Out_Pc(w_out_pc), .Out_Instr(w_out_instr),
        .Out_Class(w_out_class), .Halted(w_halted),
        .Instr_Count(w_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] cls;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [10:0] cls;
    } exp_t;

    vec_t        tbl[21];
    exp_t        sb[$];
    exp_t        mon_e;
    logic [10:0] cur_cls;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [10:0] cls);
        In_Valid = 1'b1;
        In_Pc    = pc;
        In_Instr = ins;
        cur_cls  = cls;
    endtask

    task automatic drain(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !Out_Valid) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: drain timeout, %0d left", nm, sb.size());
        end
    endtask

    // scoreboard: push on accept, pop and compare on consume
    always @(negedge clk) begin
        if (Reset) begin
            sb.delete();
        end else begin
            if (Out_Valid && Out_Ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_extra: got %h want none",
                             Out_Instr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_pc", Out_Pc, mon_e.pc);
                    chk("sb_instr", Out_Instr, mon_e.instr);
                    chk("sb_class", 32'(Out_Class), 32'(mon_e.cls));
                end
            end
            if (Flush) sb.delete();
            else if (In_Valid && In_Ready)
                sb.push_back('{In_Pc, In_Instr, cur_cls});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit taken;
        clk = 1'b0;
        Reset = 1'b1;
        In_Valid = 1'b0;
        In_Pc = '0;
        In_Instr = '0;
        Flush = 1'b0;
        Out_Ready = 1'b0;
        cur_cls = '0;

        tbl[0]  = '{32'h0050_0093, 11'h080};
        tbl[1]  = '{32'h0020_8133, 11'h100};
        tbl[2]  = '{32'h0000_A183, 11'h020};
        tbl[3]  = '{32'h0000_2063, 11'h400};
        tbl[4]  = '{32'h0000_0000, 11'h400};
        tbl[5]  = '{32'h0000_306F, 11'h004};
        tbl[6]  = '{32'h1234_5037, 11'h001};
        tbl[7]  = '{32'h0000_1097, 11'h002};
        tbl[8]  = '{32'h0000_80E7, 11'h008};
        tbl[9]  = '{32'h0000_10E7, 11'h400};
        tbl[10] = '{32'h0020_9463, 11'h010};
        tbl[11] = '{32'h0000_3063, 11'h400};
        tbl[12] = '{32'h0000_B183, 11'h400};
        tbl[13] = '{32'h0000_C183, 11'h020};
        tbl[14] = '{32'h0020_A023, 11'h040};
        tbl[15] = '{32'h0020_B023, 11'h400};
        tbl[16] = '{32'h0010_0073, 11'h200};
        tbl[17] = '{32'h0000_000F, 11'h400};
        tbl[18] = '{32'h0000_0013, 11'h080};
        tbl[19] = '{32'hFFFF_FFFF, 11'h400};
        tbl[20] = '{32'h0000_0072, 11'h400};

        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        chk("rst_out_pc", Out_Pc, 32'd0);
        chk("rst_out_instr", Out_Instr, 32'd0);
        chk("rst_out_class", 32'(Out_Class), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_count", Instr_Count, 32'd0);
        step();
        Reset = 1'b0;

        // decode table streamed back-to-back
        Out_Ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step();
            offer(32'h1000 + 32'(i) * 4, tbl[i].instr, tbl[i].cls);
            @(negedge clk);
            chk("stream_in_ready", 32'(In_Ready), 32'd1);
            if (i > 0) begin
                chk("stream_valid", 32'(Out_Valid), 32'd1);
                chk("stream_latency", Out_Instr, tbl[i-1].instr);
            end
        end
        step();
        In_Valid = 1'b0;
        drain(20, "stream");
        chk("stream_count", Instr_Count, 32'd21);
        chk("stream_wrap_count", 32'(w_cnt), 32'd5);

        // backpressure through the skid entry
        step();
        Out_Ready = 1'b0;
        offer(32'h2000, 32'h0010_0093, 11'h080);
        @(negedge clk);
        chk("bp_rdy_a", 32'(In_Ready), 32'd1);
        step();
        offer(32'h2004, 32'h0020_8133, 11'h100);
        @(negedge clk);
        chk("bp_valid_a", 32'(Out_Valid), 32'd1);
        chk("bp_head_a", Out_Instr, 32'h0010_0093);
        chk("bp_rdy_b", 32'(In_Ready), 32'd1);
        step();
        offer(32'h2008, 32'h0000_A183, 11'h020);
        @(negedge clk);
        chk("bp_full", 32'(In_Ready), 32'd0);
        chk("bp_hold_a", Out_Instr, 32'h0010_0093);
        step();
        @(negedge clk);
        chk("bp_still_full", 32'(In_Ready), 32'd0);
        chk("bp_hold_pc", Out_Pc, 32'h2000);
        step();
        Out_Ready = 1'b1;
        taken = 1'b0;
        for (int k = 0; k < 8 && !taken; k++) begin
            @(negedge clk);
            if (In_Ready) taken = 1'b1;
            step();
        end
        In_Valid = 1'b0;
        chk("bp_c_taken", 32'(taken), 32'd1);
        drain(20, "bp");
        chk("bp_count", Instr_Count, 32'd24);

        // flush with two buffered entries and an offered input
        step();
        Out_Ready = 1'b0;
        offer(32'h3000, 32'h0000_0013, 11'h080);
        step();
        offer(32'h3004, 32'h0000_0013, 11'h080);
        step();
        offer(32'h3008, 32'h0050_0093, 11'h080);
        Flush = 1'b1;
        @(negedge clk);
        chk("fl_full", 32'(In_Ready), 32'd0);
        step();
        Flush = 1'b0;
        In_Valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", 32'(Out_Valid), 32'd0);
        chk("fl_in_ready", 32'(In_Ready), 32'd1);
        chk("fl_count", Instr_Count, 32'd24);

        // flush wins over a same-cycle accept
        step();
        offer(32'h300C, 32'h0020_8133, 11'h100);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        In_Valid = 1'b0;
        @(negedge clk);
        chk("fl_drop_valid", 32'(Out_Valid), 32'd0);
        chk("fl_drop_ready", 32'(In_Ready), 32'd1);
        step();
        @(negedge clk);
        chk("fl_drop_late", 32'(Out_Valid), 32'd0);

        // flush with a same-cycle consume still counts it
        step();
        offer(32'h3010, 32'h0000_A183, 11'h020);
        step();
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        @(negedge clk);
        chk("flc_valid", 32'(Out_Valid), 32'd0);
        chk("flc_count", Instr_Count, 32'd25);

        // ECALL halt, skid drains, then reset recovers
        step();
        Out_Ready = 1'b0;
        offer(32'h4000, 32'h0000_0073, 11'h200);
        step();
        offer(32'h4004, 32'h0050_0093, 11'h080);
        step();
        offer(32'h4008, 32'h0020_8133, 11'h100);
        @(negedge clk);
        chk("ht_full", 32'(In_Ready), 32'd0);
        step();
        Out_Ready = 1'b1;
        @(negedge clk);
        chk("ht_ecall_class", 32'(Out_Class), 32'h200);
        chk("ht_not_yet", 32'(Halted), 32'd0);
        step();
        @(negedge clk);
        chk("ht_halted", 32'(Halted), 32'd1);
        chk("ht_in_ready", 32'(In_Ready), 32'd0);
        chk("ht_skid_drain", Out_Instr, 32'h0050_0093);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("ht_stay_blocked", 32'(In_Ready), 32'd0);
        end
        chk("ht_empty", 32'(Out_Valid), 32'd0);
        chk("ht_sticky", 32'(Halted), 32'd1);
        chk("ht_count", Instr_Count, 32'd27);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        In_Valid = 1'b0;
        @(negedge clk);
        chk("ht_rst_halted", 32'(Halted), 32'd0);
        chk("ht_rst_ready", 32'(In_Ready), 32'd1);
        chk("ht_rst_count", Instr_Count, 32'd0);
        chk("ht_rst_valid", 32'(Out_Valid), 32'd0);
        chk("ht_rst_wrap", 32'(w_cnt), 32'd0);

        // counter wrap on the 4-bit instance
        Out_Ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            offer(32'h5000 + 32'(i) * 4, 32'h0000_0013, 11'h080);
        end
        step();
        In_Valid = 1'b0;
        drain(20, "wrap");
        chk("wrap_full_count", Instr_Count, 32'd17);
        chk("wrap_count", 32'(w_cnt), 32'd1);

        // reset beats flush, accept and consume
        step();
        Out_Ready = 1'b0;
        offer(32'h6000, 32'h0020_8133, 11'h100);
        step();
        offer(32'h6004, 32'h0000_A183, 11'h020);
        step();
        Reset = 1'b1;
        Flush = 1'b1;
        Out_Ready = 1'b1;
        step();
        Reset = 1'b0;
        Flush = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(Out_Valid), 32'd0);
        chk("mr_count", Instr_Count, 32'd0);
        chk("mr_class", 32'(Out_Class), 32'd0);
        chk("mr_pc", Out_Pc, 32'd0);
        chk("mr_ready", 32'(In_Ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_decode_reg.md
Name: if_id_decode_reg

Overview:
- IF→ID pipeline register with a 2-entry skid buffer for the RV32I core.
- Accepts fetched {PC, instruction} from the fetch stage and pre-decodes the opcode into a registered one-hot instruction class. This class is what the downstream opcode-match gate network and the control unit consume.
- Also tracks ECALL halt and counts accepted instructions.

Parameters:
- XLEN, 32, width of PC and instruction words
- CNT_W, 32, width of the accepted-instruction counter

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- In_Valid  in  1  fetch stage presents a valid instruction
- In_Ready  out  1  block can accept; registered output
- In_Pc  in  XLEN  PC of the presented instruction
- In_Instr  in  XLEN  instruction word
- Flush  in  1  discard all buffered entries (branch/jump taken)
- Out_Valid  out  1  head entry valid
- Out_Ready  in  1  decode stage consumes head entry
- Out_Pc  out  XLEN  PC of head entry
- Out_Instr  out  XLEN  instruction of head entry
- Out_Class  out  11  one-hot class, bit order [10:0] = ILLEGAL, SYSTEM, OP, OPIMM, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI
- Halted  out  1  sticky; set when ECALL (0x00000073) is consumed at output
- Instr_Count  out  CNT_W  number of instructions consumed at output

Behaviour:
- Reset (sync, high): both entries invalid, Out_Valid=0, In_Ready=1, Out_Pc=0, Out_Instr=0, Out_Class=0, Halted=0, Instr_Count=0.
- Storage: main entry (drives outputs) and skid entry. Each entry holds {pc, instr, class}. Class is decoded on capture, so decode latency is 1 cycle from acceptance.
- Input accept when In_Valid & In_Ready. Output consume when Out_Valid & Out_Ready.
- Main empty on accept: data goes to main. Main full and not consumed: data goes to skid. Main consumed the same cycle: data goes to main, or to skid→main shift if skid is occupied.
- On a consume with skid valid: skid moves to main, and skid is refilled by any same-cycle accept.
- In_Ready (registered) = !skid_valid_next & !Halted_next. No combinational path from Out_Ready to In_Ready.
- Zero-bubble throughput: with In_Valid=Out_Ready=1 continuously, one instruction per cycle.
- Decode is pure function of instr, and exactly one class bit is set:
  - instr[1:0]≠11 → ILLEGAL.
  - opcode 0110111 LUI; 0010111 AUIPC; 1101111 JAL.
  - opcode 1100111 with funct3=000 → JALR.
  - opcode 1100011 with funct3 ∉ {010,011} → BRANCH.
  - opcode 0000011 with funct3 ∈ {000,001,010,100,101} → LOAD.
  - opcode 0100011 with funct3 ∈ {000,001,010} → STORE.
  - opcode 0010011 → OPIMM.
  - opcode 0110011 → OP.
  - opcode 1110011 → SYSTEM.
  - Anything else → ILLEGAL.
- Flush: next cycle both entries are invalid, Out_Valid=0, In_Ready=!Halted.
  - Flush beats a simultaneous accept; that input is dropped.
  - A simultaneous consume still counts, and still sets Halted if it is an ECALL.
- Halted: set on consume of instr 0x00000073. Once set, In_Ready=0 and no further accepts occur. A remaining skid entry may still drain. Halted is cleared only by Reset.
- Instr_Count: +1 per consume, wraps modulo 2^CNT_W.
- Reset mid-operation overrides Flush, accept and consume in the same cycle.

Test Plan:
- Stream: feed 0x00500093 (addi), 0x00208133 (add), 0x0000A183 (lw) back-to-back with Out_Ready=1 → outputs appear 1 cycle later with Out_Class = 0x080, 0x100, 0x020; In_Ready stays 1; Instr_Count=3.
- Backpressure: Out_Ready=0, push 3 instrs → first held at output, second in skid, In_Ready=0 after 2nd accept, 3rd not taken. Raise Out_Ready → outputs drain in order with no loss or duplication.
- Flush: 2 entries buffered plus In_Valid=1 with Flush=1 → next cycle Out_Valid=0, In_Ready=1, the offered instruction is not captured, Instr_Count unchanged.
- Halt: consume 0x00000073 → Out_Class=0x200 at consume, Halted=1 next cycle, In_Ready=0 permanently. Then Reset=1 for 1 cycle → Halted=0, In_Ready=1, Instr_Count=0.
- Illegal decode: instr 0x00002063 (BRANCH funct3=010) → Out_Class=0x400; instr 0x00000000 → 0x400; instr 0x0000306F (JAL) → 0x004.
- Counter wrap: CNT_W=4, consume 17 instructions → Instr_Count=1.
